// File: rtl/median_window_gen.sv
// 3x3 neighbourhood generator for the median sorter: two line RAMs hold the
// previous lines, a 3-column shift window presents the flattened neighbourhood.
module median_window_gen #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vsync,
    input  logic                  hsync,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     pix_in,
    output logic [9*DATA_W-1:0]   win,
    output logic                  win_valid,
    output logic                  hsync_o,
    output logic                  vsync_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] line0_mem [0:DEPTH-1];
    logic [DATA_W-1:0] line1_mem [0:DEPTH-1];

    logic [DATA_W-1:0] rd0_reg;
    logic [DATA_W-1:0] rd1_reg;
    logic [DATA_W-1:0] pix_d_reg;

    logic [1:0] line_cnt_reg;
    logic [1:0] line_cnt_next;
    logic [1:0] col_cnt_reg;
    logic [1:0] col_cnt_next;
    logic       armed_reg;
    logic       armed_next;
    logic       v0;

    logic [1:0] valid_pipe_reg;
    logic [1:0] hs_pipe_reg;
    logic [1:0] vs_pipe_reg;

    // Line 1 inherits what line 0 held at this address before this cycle's write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            line0_mem[addr] <= pix_in;
            line1_mem[addr] <= line0_mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd0_reg   <= '0;
            rd1_reg   <= '0;
            pix_d_reg <= '0;
        end else begin
            rd0_reg   <= line0_mem[addr];
            rd1_reg   <= line1_mem[addr];
            pix_d_reg <= pix_in;
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            logic [DATA_W-1:0] tap_reg [3];
            logic [DATA_W-1:0] new_tap;

            // Row 0 is the oldest line, row 2 the live pixel stream.
            assign new_tap = (gi == 0) ? rd1_reg :
                             (gi == 1) ? rd0_reg : pix_d_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    tap_reg[0] <= '0;
                    tap_reg[1] <= '0;
                    tap_reg[2] <= '0;
                end else begin
                    tap_reg[0] <= tap_reg[1];
                    tap_reg[1] <= tap_reg[2];
                    tap_reg[2] <= new_tap;
                end
            end

            for (gj = 0; gj < 3; gj++) begin : g_col
                assign win[(3*gi+gj)*DATA_W +: DATA_W] = tap_reg[gj];
            end
        end
    endgenerate

    // vsync wins over hsync; armed gates validity until a frame start follows a reset.
    always_comb begin
        line_cnt_next = line_cnt_reg;
        col_cnt_next  = col_cnt_reg;
        armed_next    = armed_reg;
        if (vsync) begin
            line_cnt_next = 2'd0;
            col_cnt_next  = 2'd0;
            armed_next    = 1'b1;
        end else if (hsync) begin
            if (line_cnt_reg != 2'd3) begin
                line_cnt_next = line_cnt_reg + 2'd1;
            end
            col_cnt_next = 2'd1;
        end else if (col_cnt_reg != 2'd3) begin
            col_cnt_next = col_cnt_reg + 2'd1;
        end
    end

    assign v0 = !rst && !vsync && !hsync && armed_reg &&
                (line_cnt_reg == 2'd3) && (col_cnt_reg >= 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            line_cnt_reg   <= 2'd0;
            col_cnt_reg    <= 2'd0;
            armed_reg      <= 1'b0;
            valid_pipe_reg <= 2'b00;
            hs_pipe_reg    <= 2'b00;
            vs_pipe_reg    <= 2'b00;
        end else begin
            line_cnt_reg   <= line_cnt_next;
            col_cnt_reg    <= col_cnt_next;
            armed_reg      <= armed_next;
            valid_pipe_reg <= {valid_pipe_reg[0], v0};
            hs_pipe_reg    <= {hs_pipe_reg[0], hsync};
            vs_pipe_reg    <= {vs_pipe_reg[0], vsync};
        end
    end

    assign win_valid = valid_pipe_reg[1];
    assign hsync_o   = hs_pipe_reg[1];
    assign vsync_o   = vs_pipe_reg[1];

endmodule

// File: tb/tb_median_window_gen.sv
// Scoreboard bench for median_window_gen: the driver queues the expected output
// for every input cycle, a monitor pops and compares two cycles later.
module tb_median_window_gen;

    localparam int DW = 8;
    localparam int AW = 11;
    localparam int WW = 9 * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vsync = 1'b0;
    logic          hsync = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] pix_in = '0;
    logic [WW-1:0] win;
    logic          win_valid;
    logic          hsync_o;
    logic          vsync_o;

    median_window_gen #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .vsync     (vsync),
        .hsync     (hsync),
        .addr      (addr),
        .pix_in    (pix_in),
        .win       (win),
        .win_valid (win_valid),
        .hsync_o   (hsync_o),
        .vsync_o   (vsync_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            due;
        logic          ev;
        logic          ehs;
        logic          evs;
        logic          cw;
        logic [WW-1:0] ew;
        int            tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check_bit(input string nm, input int tag, input logic act, input logic req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s tag=%0d cyc=%0d actual=%b required=%b", nm, tag, cyc, act, req);
    endtask

    task automatic check_win(input int tag, input logic [WW-1:0] act, input logic [WW-1:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL win tag=%0d cyc=%0d actual=%h required=%h", tag, cyc, act, req);
    endtask

    // Monitor: compare every queued expectation on the cycle it falls due.
    initial begin
        exp_t m;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                m = exp_q.pop_front();
                if (m.due < cyc) begin
                    n_total++;
                    $display("FAIL stale tag=%0d due=%0d cyc=%0d", m.tag, m.due, cyc);
                end else begin
                    check_bit("win_valid", m.tag, win_valid, m.ev);
                    check_bit("hsync_o", m.tag, hsync_o, m.ehs);
                    check_bit("vsync_o", m.tag, vsync_o, m.evs);
                    if (m.cw) check_win(m.tag, win, m.ew);
                end
            end
        end
    end

    task automatic step(input logic r, input logic v, input logic h,
                        input logic [DW-1:0] p, input logic [AW-1:0] a,
                        input logic ev, input logic cw, input logic [WW-1:0] ew,
                        input int tag);
        exp_t e;
        @(negedge clk);
        rst = r; vsync = v; hsync = h; pix_in = p; addr = a;
        // A reset clears everything still in flight: those outputs must read zero.
        if (r) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i].due > cyc) begin
                    e = exp_q[i];
                    e.ev = 1'b0; e.ehs = 1'b0; e.evs = 1'b0; e.cw = 1'b1; e.ew = '0;
                    exp_q[i] = e;
                end
            end
        end
        e.due = cyc + 2; e.ev = ev; e.ehs = h & ~r; e.evs = v & ~r;
        e.cw = cw; e.ew = ew; e.tag = tag;
        exp_q.push_back(e);
    endtask

    // 8-pixel lines, pix = base + 16*row + col, addr = col; vsync on row 0 col 0.
    task automatic run_frame(input int fid, input logic [DW-1:0] base, input int nrows,
                             input logic both, input int rst_row, input int rst_col);
        bit            dead = 0;
        logic          v, h, r, ev, cw;
        logic [WW-1:0] ew;
        for (int row = 0; row < nrows; row++) begin
            for (int col = 0; col < 8; col++) begin
                v  = (row == 0 && col == 0);
                h  = (col == 0) && (row != 0 || both);
                r  = (row == rst_row && col == rst_col);
                ev = 1'b0; cw = 1'b0; ew = '0;
                if (r) begin
                    dead = 1;
                    cw   = 1'b1;
                end else if (!dead && row >= 3 && col >= 2) begin
                    ev = 1'b1;
                    cw = 1'b1;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            ew[(3*i+j)*DW +: DW] = base + 8'(16*(row-2+i) + (col-2+j));
                    if (fid == 1 && row == 3 && col == 2)
                        ew = 72'h32_31_30_22_21_20_12_11_10;
                end
                step(r, v, h, base + 8'(16*row + col), AW'(col), ev, cw, ew,
                     fid*1000 + row*10 + col);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b0, 8'($urandom), AW'($urandom), 1'b0, 1'b1, '0, 100 + i);
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 200 + i);

        run_frame(1, 8'h00, 8, 1'b0, -1, -1);  // ramp frame
        run_frame(2, 8'h80, 6, 1'b0, -1, -1);  // cut short after row 5
        run_frame(3, 8'h08, 8, 1'b1, -1, -1);  // vsync and hsync together
        run_frame(4, 8'h40, 8, 1'b0, 4, 5);    // reset mid-line
        run_frame(5, 8'h00, 5, 1'b0, -1, -1);  // recovery after reset

        repeat (4) @(negedge clk);
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain actual=%0d pending required=0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
